// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the RV64 core pipeline: elastic stage
//                state encoding, the packed payload structs carried between
//                IF/ID, ID/EX, EX/MEM and MEM/WB, and a small decode helper
//                for stage occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // --------------------------------------------------------------------------
  // Architectural widths
  // --------------------------------------------------------------------------
  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int ALU_OP_W    = 5;
  localparam int LSU_OP_W    = 4;
  localparam int BRANCH_OP_W = 3;
  localparam int MUL_OP_W    = 4;

  // --------------------------------------------------------------------------
  // Elastic pipeline stage state.
  // Occupancy is implied by the state: EMPTY=0, HALF=1, FULL=2 entries.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_HALF  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  // --------------------------------------------------------------------------
  // IF/ID payload
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
  } if_id_t;

  // --------------------------------------------------------------------------
  // ID/EX control bits. Kept as a separate struct so that a zeroed bubble
  // is obviously "no side effects" (reg_write=0, mem_*=0).
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic is_branch;
    logic is_jump;
    logic alu_src_imm;
    logic alu_src_pc;
    logic csr_en;
    logic mul_en;
    logic div_en;
    logic is_fence;
    logic is_ecall;
    logic illegal;
  } id_ex_ctrl_t;

  // --------------------------------------------------------------------------
  // ID/EX payload (300 bits)
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic [XLEN-1:0]        imm;
    logic [REG_ADDR_W-1:0]  rs1_addr;
    logic [REG_ADDR_W-1:0]  rs2_addr;
    logic [REG_ADDR_W-1:0]  rd_addr;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [LSU_OP_W-1:0]    lsu_op;
    logic [BRANCH_OP_W-1:0] branch_op;
    logic [MUL_OP_W-1:0]    mul_op;
    id_ex_ctrl_t            ctrl;
  } id_ex_t;

  // --------------------------------------------------------------------------
  // EX/MEM payload
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [LSU_OP_W-1:0]   lsu_op;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_mem_t;

  // --------------------------------------------------------------------------
  // MEM/WB payload
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
  } mem_wb_t;

  // --------------------------------------------------------------------------
  // Occupancy of a stage in a given state.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] pipe_count(input pipe_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PIPE_EMPTY: n = 2'd0;
      PIPE_HALF:  n = 2'd1;
      PIPE_FULL:  n = 2'd2;
      default:    n = 2'd0;
    endcase
    return n;
  endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Handshake bundle of one elastic pipeline stage. Carries the
//                upstream side (valid_i/ready_o/data_i), the downstream side
//                (valid_o/ready_i/data_o), the synchronous flush and the
//                occupancy report.
//  Modports    : master - the surrounding pipeline / environment
//                slave  - the stage register itself
//  Parameters  : WIDTH - payload width in bits (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64
);

  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       count_o;

  modport master (
    output flush_i,
    output valid_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  count_o
  );

  modport slave (
    input  flush_i,
    input  valid_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output count_o
  );

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic elastic valid/ready pipeline register carrying a
//                packed payload. Supports synchronous flush, occupancy
//                reporting and optional zeroing of vacated entries.
//  Build macro : PIPE_SKID_EN
//                  defined   - two-entry skid stage (main_q + skid_q); all
//                              outputs are decoded from registers only.
//                  undefined - single-entry stage; ready_o is the
//                              combinational !valid_o || ready_i.
//  Parameters  : WIDTH        - payload width in bits (>= 1)
//                ZERO_INVALID - 1: clear payload registers when vacated
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - pipe_stage_reg_if.slave (flush_i, valid_i, ready_o,
//                        data_i, valid_o, ready_i, data_o, count_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter bit ZERO_INVALID = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_stage_reg_if.slave        bus
);

  pipe_state_e      state_q;
  logic [WIDTH-1:0] main_q;

  logic w_valid;
  logic w_ready;
  logic w_push;
  logic w_pop;

  assign w_valid = (state_q != PIPE_EMPTY);

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q;

  // Registered-only ready: a downstream stall is absorbed by skid_q, so the
  // upstream sees ready drop one cycle late.
  assign w_ready = (state_q != PIPE_FULL);
`else
  // Single entry: we can take a new beat whenever the head leaves this cycle.
  assign w_ready = !w_valid || bus.ready_i;
`endif

  assign w_push = bus.valid_i && w_ready;
  assign w_pop  = w_valid && bus.ready_i;

`ifdef PIPE_SKID_EN
  // --------------------------------------------------------------------------
  // Two-entry stage. main_q is always the head; skid_q only holds the beat
  // that arrived while the head was stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (bus.flush_i) begin
      // A pop in this cycle has already been sampled downstream, and any
      // incoming beat is dropped, so both registers simply become empty.
      state_q <= PIPE_EMPTY;
      if (ZERO_INVALID) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (w_push) begin
            state_q <= PIPE_HALF;
            main_q  <= bus.data_i;
          end
        end
        PIPE_HALF: begin
          if (w_push && w_pop) begin
            main_q <= bus.data_i;
          end else if (w_push) begin
            state_q <= PIPE_FULL;
            skid_q  <= bus.data_i;
          end else if (w_pop) begin
            state_q <= PIPE_EMPTY;
            if (ZERO_INVALID) begin
              main_q <= '0;
            end
          end
        end
        PIPE_FULL: begin
          // No push is possible here: ready is low while FULL.
          if (w_pop) begin
            state_q <= PIPE_HALF;
            main_q  <= skid_q;
            if (ZERO_INVALID) begin
              skid_q <= '0;
            end
          end
        end
        default: begin
          state_q <= PIPE_EMPTY;
        end
      endcase
    end
  end
`else
  // --------------------------------------------------------------------------
  // Single-entry stage. FULL is never entered.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PIPE_EMPTY;
      main_q  <= '0;
    end else if (bus.flush_i) begin
      state_q <= PIPE_EMPTY;
      if (ZERO_INVALID) begin
        main_q <= '0;
      end
    end else begin
      case (state_q)
        PIPE_EMPTY: begin
          if (w_push) begin
            state_q <= PIPE_HALF;
            main_q  <= bus.data_i;
          end
        end
        PIPE_HALF: begin
          // A push while HALF implies the head is leaving in the same cycle.
          if (w_push) begin
            main_q <= bus.data_i;
          end else if (w_pop) begin
            state_q <= PIPE_EMPTY;
            if (ZERO_INVALID) begin
              main_q <= '0;
            end
          end
        end
        default: begin
          state_q <= PIPE_EMPTY;
        end
      endcase
    end
  end
`endif

  assign bus.valid_o = w_valid;
  assign bus.ready_o = w_ready;
  assign bus.data_o  = main_q;
  assign bus.count_o = pipe_count(state_q);

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. Two instances run
//                side by side: WIDTH=$bits(id_ex_t) (300) and WIDTH=1. A
//                queue-based reference model per instance predicts valid,
//                ready, count and head data every cycle. Directed scenarios
//                precede a long random valid/ready/flush run.
//  Build macro : PIPE_SKID_EN selects the two-entry expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;
  import riscv_pkg::*;

  localparam int WA = $bits(id_ex_t);

  logic clk = 1'b0;
  logic rst_n;

  pipe_stage_reg_if #(.WIDTH(WA)) bus_a ();
  pipe_stage_reg_if #(.WIDTH(1))  bus_b ();

  pipe_stage_reg #(.WIDTH(WA), .ZERO_INVALID(1'b1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  pipe_stage_reg #(.WIDTH(1), .ZERO_INVALID(1'b1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the stage is a FIFO whose contents are these queues.
  logic [WA-1:0] qa[$];
  logic          qb[$];

  bit            pop_seen_a;
  logic [WA-1:0] pop_val_a;

  task automatic chk_eq(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Capacity: 2 entries with skid; otherwise 1 entry that may be replaced
  // in the same cycle it leaves.
  function automatic bit exp_ready_a(input bit r);
`ifdef PIPE_SKID_EN
    return qa.size() < 2;
`else
    return (qa.size() == 0) || r;
`endif
  endfunction

  function automatic bit exp_ready_b(input bit r);
`ifdef PIPE_SKID_EN
    return qb.size() < 2;
`else
    return (qb.size() == 0) || r;
`endif
  endfunction

  function automatic logic [WA-1:0] rand_wa();
    logic [WA-1:0] r;
    r = '0;
    for (int k = 0; k < (WA + 31) / 32; k++) begin
      r = {r[WA-33:0], 32'($urandom)};
    end
    return r;
  endfunction

  // One clock cycle: called just after a rising edge. Drives inputs, checks
  // the outputs against the model mid-cycle, then advances the model.
  task automatic cyc(input bit va, input logic [WA-1:0] da, input bit ra, input bit fa,
                     input bit vb, input logic db, input bit rb, input bit fb);
    bit push_a, pop_a, push_b, pop_b;
    bus_a.valid_i = va;
    bus_a.data_i  = da;
    bus_a.ready_i = ra;
    bus_a.flush_i = fa;
    bus_b.valid_i = vb;
    bus_b.data_i  = db;
    bus_b.ready_i = rb;
    bus_b.flush_i = fb;
    @(negedge clk);
    chk_eq("a_valid", WA'(bus_a.valid_o), WA'(qa.size() != 0));
    chk_eq("a_ready", WA'(bus_a.ready_o), WA'(exp_ready_a(ra)));
    chk_eq("a_count", WA'(bus_a.count_o), WA'(qa.size()));
    chk_eq("a_data",  bus_a.data_o, (qa.size() != 0) ? qa[0] : '0);
    chk_eq("b_valid", WA'(bus_b.valid_o), WA'(qb.size() != 0));
    chk_eq("b_ready", WA'(bus_b.ready_o), WA'(exp_ready_b(rb)));
    chk_eq("b_count", WA'(bus_b.count_o), WA'(qb.size()));
    chk_eq("b_data",  WA'(bus_b.data_o), (qb.size() != 0) ? WA'(qb[0]) : '0);
    push_a     = va && exp_ready_a(ra);
    pop_a      = (qa.size() != 0) && ra;
    push_b     = vb && exp_ready_b(rb);
    pop_b      = (qb.size() != 0) && rb;
    pop_seen_a = pop_a;
    pop_val_a  = bus_a.data_o;
    @(posedge clk);
    #1;
    if (pop_a) void'(qa.pop_front());
    if (fa) qa.delete();
    else if (push_a) qa.push_back(da);
    if (pop_b) void'(qb.pop_front());
    if (fb) qb.delete();
    else if (push_b) qb.push_back(db);
  endtask

  task automatic cyc_a(input bit va, input logic [WA-1:0] da, input bit ra, input bit fa);
    cyc(va, da, ra, fa, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt_in, nxt_out;
    rst_n = 1'b0;
    bus_a.valid_i = 1'b0; bus_a.data_i = '0; bus_a.ready_i = 1'b0; bus_a.flush_i = 1'b0;
    bus_b.valid_i = 1'b0; bus_b.data_i = '0; bus_b.ready_i = 1'b0; bus_b.flush_i = 1'b0;

    // ---------------- reset values ----------------
    @(negedge clk);
    chk_eq("rst_valid", WA'(bus_a.valid_o), WA'(0));
    chk_eq("rst_ready", WA'(bus_a.ready_o), WA'(1));
    chk_eq("rst_count", WA'(bus_a.count_o), WA'(0));
    chk_eq("rst_data",  bus_a.data_o, WA'(0));
    chk_eq("rst_b_ready", WA'(bus_b.ready_o), WA'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- single push 0xA5 ----------------
    cyc_a(1'b1, WA'(8'hA5), 1'b1, 1'b0);
    chk_eq("a5_valid", WA'(bus_a.valid_o), WA'(1));
    chk_eq("a5_data",  bus_a.data_o, WA'(8'hA5));
    chk_eq("a5_count", WA'(bus_a.count_o), WA'(1));
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    chk_eq("a5_gone_valid", WA'(bus_a.valid_o), WA'(0));
    chk_eq("a5_gone_data",  bus_a.data_o, WA'(0));

`ifdef PIPE_SKID_EN
    // ---------------- skid absorbs one beat on stall ----------------
    cyc_a(1'b1, WA'(1), 1'b1, 1'b0);
    cyc_a(1'b1, WA'(2), 1'b1, 1'b0);
    cyc_a(1'b1, WA'(3), 1'b0, 1'b0);
    chk_eq("skid_head",  bus_a.data_o, WA'(2));
    chk_eq("skid_ready", WA'(bus_a.ready_o), WA'(0));
    chk_eq("skid_count", WA'(bus_a.count_o), WA'(2));
    cyc_a(1'b1, WA'(4), 1'b1, 1'b0);
    chk_eq("skid_out3", bus_a.data_o, WA'(3));
    cyc_a(1'b1, WA'(4), 1'b1, 1'b0);
    chk_eq("skid_out4", bus_a.data_o, WA'(4));
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    chk_eq("skid_empty", WA'(bus_a.count_o), WA'(0));
`endif

    // ---------------- stream 10..20 with toggling ready ----------------
    nxt_in  = 10;
    nxt_out = 10;
    for (int c = 0; c < 80 && nxt_out <= 20; c++) begin
      bit r, acc;
      r   = c[0];
      acc = (nxt_in <= 20) && exp_ready_a(r);
      cyc_a(nxt_in <= 20, WA'(nxt_in), r, 1'b0);
      if (acc) nxt_in++;
      if (pop_seen_a) begin
        chk_eq("stream_order", pop_val_a, WA'(nxt_out));
        nxt_out++;
      end
    end
    chk_eq("stream_done", WA'(nxt_out), WA'(21));
    cyc_a(1'b0, '0, 1'b1, 1'b0);

    // ---------------- flush while full, with a colliding push ----------------
    cyc_a(1'b1, WA'(8'h11), 1'b0, 1'b0);
    cyc_a(1'b1, WA'(8'h22), 1'b0, 1'b0);
    cyc_a(1'b1, WA'(8'h77), 1'b0, 1'b1);
    chk_eq("flush_valid", WA'(bus_a.valid_o), WA'(0));
    chk_eq("flush_count", WA'(bus_a.count_o), WA'(0));
    chk_eq("flush_data",  bus_a.data_o, WA'(0));
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    cyc_a(1'b0, '0, 1'b1, 1'b0);

    // ---------------- asynchronous reset mid-stream ----------------
    cyc_a(1'b1, WA'(5), 1'b0, 1'b0);
    cyc_a(1'b1, WA'(6), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", WA'(bus_a.valid_o), WA'(0));
    chk_eq("arst_count", WA'(bus_a.count_o), WA'(0));
    chk_eq("arst_ready", WA'(bus_a.ready_o), WA'(1));
    chk_eq("arst_data",  bus_a.data_o, WA'(0));
    qa.delete();
    qb.delete();
    bus_a.valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc_a(1'b1, WA'(1), 1'b1, 1'b0);
    chk_eq("post_rst_data",  bus_a.data_o, WA'(1));
    chk_eq("post_rst_count", WA'(bus_a.count_o), WA'(1));
    cyc_a(1'b0, '0, 1'b1, 1'b0);
    chk_eq("post_rst_alone", WA'(bus_a.valid_o), WA'(0));

    // ---------------- random valid/ready/flush on both widths ----------------
    for (int c = 0; c < 10000; c++) begin
      cyc($urandom_range(0, 3) != 0, rand_wa(), $urandom_range(0, 1) != 0,
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 2) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for the RV64 core. It replaces hand-written, per-stage fixed registers with a generic valid/ready stage carrying a packed payload. The stage supports an optional two-entry skid buffer, synchronous flush and occupancy reporting. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, with each stage's packed struct as the payload. Back-pressure from multi-cycle units (MUL/DIV, LSU) propagates via `ready`, not a global stall.

## Interface
- `WIDTH`, default 64: payload width in bits; legal range ≥1. The ID/EX stage instantiates it with `$bits(id_ex_t)`.
- `ZERO_INVALID`, default 1: when 1, payload registers are cleared to 0 whenever their entry is vacated (pop, flush, reset), so `data_o` reads 0 while `valid_o`=0.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous kill of all held entries.
- `valid_i` in 1: upstream offers `data_i`.
- `ready_o` out 1: stage can accept this cycle.
- `data_i` in WIDTH: upstream payload.
- `valid_o` out 1: `data_o` is valid.
- `ready_i` in 1: downstream accepts this cycle.
- `data_o` out WIDTH: head payload.
- `count_o` out 2: occupancy, 0..2.

## Operation
- Transfer in: `valid_i && ready_o`. Transfer out: `valid_o && ready_i`. Both are sampled at the rising edge.
- Skid mode (see Configuration) uses state `PIPE_EMPTY`/`PIPE_HALF`/`PIPE_FULL` and two registers, `main_q` (the head) and `skid_q`.
  - In EMPTY, in → HALF, `main_q<=data_i`.
  - In HALF:
    - in & out → HALF, `main_q<=data_i`.
    - in only → FULL, `skid_q<=data_i`.
    - out only → EMPTY.
    - idle → HALF.
  - In FULL, out → HALF, `main_q<=skid_q`. No input is accepted while FULL.
- `valid_o` = (state≠EMPTY); `ready_o` = (state≠FULL). Both are decoded from registered state only.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush has the highest priority. On flush the next state is EMPTY and every entry is discarded. An input handshaking in the same cycle is discarded. An output handshake in the same cycle still completes, because downstream sampled it.
- `count_o` = 0/1/2 for EMPTY/HALF/FULL.
- If `ZERO_INVALID`=1, vacated registers are written 0. This matches the zeroed-bubble behaviour the downstream forwarding logic relies on: rd=0, reg_write=0.

## Timing
- Reset values: `valid_o`=0, `data_o`=0, `count_o`=0, `ready_o`=1, state EMPTY. In the non-skid build, `ready_o`=1 after reset via its equation.
- Latency: a payload accepted at edge N is presented on `data_o`/`valid_o` after edge N. Throughput is one transfer per cycle in both directions.
- Skid build: no combinational path from `ready_i` or `valid_i` to any output. A downstream stall costs upstream exactly one extra accepted beat, which lands in skid, before `ready_o` drops.
- Non-skid build: `ready_o` = `!valid_o || ready_i`, a combinational path from `ready_i`.
- Reset asserted mid-operation clears state immediately, without waiting for a clock.
- `flush_i` is sampled only at the clock edge. Its effect is visible the cycle after it is asserted.

## Configuration
- `PIPE_SKID_EN` defined: two-entry skid build as above; `count_o` reaches 2.
- `PIPE_SKID_EN` undefined: single entry, no `skid_q`, no FULL state.
  - Simultaneous pop and push in HALF stays HALF with the new data.
  - `count_o` ≤ 1.
  - `ready_o` is the combinational equation given in Timing.
- The ports are identical in both builds.

## Structure
- `riscv_pkg` gets `typedef enum logic [1:0] {PIPE_EMPTY, PIPE_HALF, PIPE_FULL} pipe_state_e`.
- `riscv_pkg` also gets the packed stage payload structs: `if_id_t`, `id_ex_t`, `ex_mem_t`, `mem_wb_t`. The `id_ex_t` fields are pc, rs1/rs2 data, imm, rs1/rs2/rd addr, alu/lsu/branch/mul ops, and the control bits.
- No sub-module; the stage is one flat module. Per-stage wrappers only pack and unpack structs.

## Test plan
- Reset, then push 0xA5 with `ready_i`=1: `valid_o`=1 with `data_o`=0xA5 one cycle later, `count_o`=1. Push then stops; the next cycle gives `valid_o`=0, `data_o`=0.
- Skid build: stream 1,2,3,4 and drop `ready_i` after 1 is taken. Response: 2 is in main and 3 is in skid, `ready_o`=0, `count_o`=2. Raising `ready_i` delivers 2,3,4 in order with no loss.
- Non-skid build: continuous stream 10..20 with `ready_i` toggling every cycle. Output order is 10..20 and `ready_o` tracks `!valid_o||ready_i` each cycle.
- Fill FULL, then assert `flush_i` with `valid_i`=1 and data 0x77. Next cycle: `valid_o`=0, `count_o`=0, `data_o`=0, and 0x77 never appears.
- Pull `rst_n` low asynchronously mid-stream with the stage FULL. Outputs go to reset values before the next edge; after release the first push of 0x1 emerges alone.
- With `WIDTH`=1 and `WIDTH`=300 (id_ex_t size), random valid/ready for 10k cycles against a scoreboard: in-order with no loss or duplication, and `count_o` matches the model every cycle.
